addsub_pipe: RTL
================

Name: addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit with Z/V/N/C flags. It succeeds the single-cycle 32-bit combinational subtractor.
- Width and pipeline depth are generic. It supports add and sub modes, with signed or unsigned flag semantics.
- It has a valid/ready handshake with backpressure and a sideband tag that passes through unchanged.
- It sits in the ALU/execute path and feeds branch-compare and SLT logic.

Parameters:
- WIDTH, 32: operand/result width.
- STAGES, 2: pipeline depth, range 1..4. WIDTH must be divisible by STAGES; a non-divisible value is an elaboration error.
- TAG_W, 4: width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  an operation is presented on a, b, sub, sign and in_tag.
- in_ready  out  1  the unit accepts the operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = compute A-B; 0 = compute A+B.
- sign  in  1  1 = signed flag semantics; 0 = unsigned.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  a result is present on the outputs.
- out_ready  in  1  the consumer takes the result this cycle.
- s  out  WIDTH  result.
- z  out  1  zero flag.
- v  out  1  overflow/borrow flag.
- n  out  1  negative flag.
- c  out  1  raw carry out of the MSB.
- out_tag  out  TAG_W  tag of the result on the outputs.

Behaviour:
- Arithmetic:
  - Internal operation is A + B' + cin, with B' = sub ? ~b : b and cin = sub.
  - The sum wraps modulo 2^WIDTH; c is the carry out of the MSB.
- Slicing:
  - The datapath is split into STAGES chunks of CW = WIDTH/STAGES bits.
  - Stage k adds chunk k using the carry registered from stage k-1.
  - Stage k forwards the not-yet-added operand chunks and the already-added result chunks.
  - A per-chunk zero bit is accumulated from stage to stage.
- Flags, formed in the final stage:
  - z = (s == 0), in both modes.
  - Unsigned: n = 0. For sub, v = ~c (borrow, i.e. A<B unsigned). For add, v = c.
  - Signed: n = s[MSB]. v = (a[MSB] == B'[MSB]) && (s[MSB] != a[MSB]).
- Latency and throughput:
  - out_valid rises exactly STAGES cycles after an accepted in_valid, provided out_ready is not stalling.
  - Throughput is one operation per cycle.
- Handshake:
  - Global enable en = ~out_valid | out_ready.
  - in_ready = en. An operation is accepted when in_valid & in_ready.
  - When en = 0, all pipeline registers hold.
  - s, flags and out_tag are stable while out_valid & ~out_ready.
  - A bubble (in_valid = 0 while en = 1) propagates as valid = 0.
  - Operations complete in order; none are dropped or duplicated.
- Reset:
  - Clears all stage valid bits: out_valid = 0, in_ready = 1.
  - s, z, v, n, c and out_tag all reset to 0.
  - Reset asserted mid-operation discards all in-flight operations. The first operation after reset deasserts is accepted normally.
- Boundary conditions:
  - STAGES = 1 gives a single register stage.
  - in_valid together with out_ready in the same cycle while full: one result leaves and one operation enters; there is no gap.
  - out_ready with out_valid = 0 is ignored.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- With the macro defined:
  - An extra input port sat (1 bit) is added and pipelined with the operation.
  - When sat = 1 and v = 1, s clamps:
    - unsigned add → all ones;
    - unsigned sub → 0;
    - signed → max positive if a[MSB] = 0, otherwise min negative.
  - v still reports that overflow occurred. z and n are computed from the clamped s.
  - c is the raw carry.
- Without the macro: there is no sat port and results always wrap.

Decomposition:
- Package addsub_pkg holds:
  - the op encoding constants (OP_ADD = 0, OP_SUB = 1; SIGN_U = 0, SIGN_S = 1);
  - a flag-bundle typedef {z, v, n, c};
  - a helper function for the clamp constants.
- One sub-module: addsub_chunk. It is a CW-bit slice adder with inputs a, b', cin and outputs sum, cout, is_zero. It is instantiated once per stage.

Test Plan (WIDTH = 32, STAGES = 2):
- Unsigned sub 5-7 → after 2 cycles: s = 0xFFFFFFFE, v = 1, n = 0, z = 0, c = 0.
- Signed sub 0x80000000-1 → s = 0x7FFFFFFF, v = 1, n = 0. Signed sub 3-3 → s = 0, z = 1, v = 0, n = 0.
- Unsigned add 0xFFFFFFFF+1 → s = 0, z = 1, v = 1, c = 1. With ADDSUB_SAT_EN and sat = 1 → s = 0xFFFFFFFF, z = 0.
- Four back-to-back ops, tags 1..4, with out_ready low on cycles 3-5 → in_ready low during the stall, outputs held stable, results emitted in tag order 1..4 with no loss.
- Reset pulsed for one cycle with 2 ops in flight → out_valid = 0 next cycle and all outputs 0. The next op gives correct results 2 cycles after acceptance.
- Continuous in_valid with out_ready = 1 → one result per cycle, latency exactly 2.

Source files
------------

// File: rtl/addsub_pkg.sv
// ============================================================================
// Module      : addsub_pkg
// Description : Shared definitions for the pipelined add/subtract unit:
//               operation/sign encodings, the result flag bundle and a
//               helper that selects the saturation clamp value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam logic SIGN_U = 1'b0;
    localparam logic SIGN_S = 1'b1;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
        logic c;
    } flags_t;

    typedef enum logic [1:0] {
        CLAMP_ZERO   = 2'd0,
        CLAMP_ONES   = 2'd1,
        CLAMP_MAXPOS = 2'd2,
        CLAMP_MINNEG = 2'd3
    } clamp_e;

    // Which rail an overflowing result saturates to. For signed operation
    // the true result has the sign of A whenever overflow is possible, so
    // A's MSB picks the rail.
    function automatic clamp_e clamp_kind(input logic sign, input logic sub,
                                          input logic a_msb);
        clamp_e kind;
        if (sign == SIGN_S) begin
            kind = a_msb ? CLAMP_MINNEG : CLAMP_MAXPOS;
        end else begin
            kind = (sub == OP_SUB) ? CLAMP_ZERO : CLAMP_ONES;
        end
        return kind;
    endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_chunk.sv
// ============================================================================
// Module      : addsub_chunk
// Description : CW-bit slice adder used once per pipeline stage.
//   i_a, i_bp  : operand slices (i_bp is B already conditionally inverted)
//   i_cin      : carry into the slice
//   o_sum      : slice sum
//   o_cout     : carry out of the slice MSB
//   o_is_zero  : slice sum is all zeros
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_chunk #(
    parameter int CW = 16
) (
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_bp,
    input  logic          i_cin,
    output logic [CW-1:0] o_sum,
    output logic          o_cout,
    output logic          o_is_zero
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_bp} + {{CW{1'b0}}, i_cin};
    assign o_is_zero       = ~|o_sum;

endmodule

`default_nettype wire

// File: rtl/addsub_pipe.sv
// ============================================================================
// Module      : addsub_pipe
// Description : Pipelined WIDTH-bit add/subtract unit with Z/V/N/C flags and
//               a valid/ready handshake. The carry chain is cut into STAGES
//               slices of WIDTH/STAGES bits, one slice added per stage.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : operation handshake (a, b, sub, sign, in_tag)
//   out_valid/out_ready   : result handshake (s, z, v, n, c, out_tag)
//   sat (ADDSUB_SAT_EN)   : clamp the result on overflow instead of wrapping
// Optional feature macro : ADDSUB_SAT_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sign,
`ifdef ADDSUB_SAT_EN
    input  logic             sat,
`endif
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             z,
    output logic             v,
    output logic             n,
    output logic             c,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW  = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    if ((STAGES < 1) || (STAGES > 4) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("addsub_pipe: STAGES must be 1..4 and divide WIDTH");
    end

    // Inputs seen by each stage: index 0 comes from the ports, index k from
    // the registers of stage k-1.
    logic             w_vld_in  [STAGES];
    logic [WIDTH-1:0] w_a_in    [STAGES];
    logic [WIDTH-1:0] w_bp_in   [STAGES];
    logic [WIDTH-1:0] w_res_in  [STAGES];
    logic             w_cin_in  [STAGES];
    logic             w_z_in    [STAGES];
    logic             w_sub_in  [STAGES];
    logic             w_sign_in [STAGES];
    logic [TAG_W-1:0] w_tag_in  [STAGES];
`ifdef ADDSUB_SAT_EN
    logic             w_sat_in  [STAGES];
`endif

    logic             r_out_valid;
    logic [WIDTH-1:0] r_s;
    flags_t           r_flags;
    logic [TAG_W-1:0] r_out_tag;
    logic             w_en;

    // One global enable: the whole pipe advances or the whole pipe holds.
    assign w_en     = ~r_out_valid | out_ready;
    assign in_ready = w_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW-1:0]    w_sum;
        logic             w_cout;
        logic             w_czero;
        logic [WIDTH-1:0] w_res_nx;
        logic             w_z_nx;

        if (k == 0) begin : g_entry
            assign w_vld_in[0]  = in_valid;
            assign w_a_in[0]    = a;
            assign w_bp_in[0]   = (sub == OP_SUB) ? ~b : b;
            assign w_res_in[0]  = '0;
            assign w_cin_in[0]  = (sub == OP_SUB);
            assign w_z_in[0]    = 1'b1;
            assign w_sub_in[0]  = sub;
            assign w_sign_in[0] = sign;
            assign w_tag_in[0]  = in_tag;
`ifdef ADDSUB_SAT_EN
            assign w_sat_in[0]  = sat;
`endif
        end

        addsub_chunk #(.CW(CW)) u_chunk (
            .i_a       (w_a_in[k][k*CW +: CW]),
            .i_bp      (w_bp_in[k][k*CW +: CW]),
            .i_cin     (w_cin_in[k]),
            .o_sum     (w_sum),
            .o_cout    (w_cout),
            .o_is_zero (w_czero)
        );

        always_comb begin
            w_res_nx                = w_res_in[k];
            w_res_nx[k*CW +: CW]    = w_sum;
        end

        assign w_z_nx = w_z_in[k] & w_czero;

        if (k < STAGES - 1) begin : g_mid
            logic             r_vld;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_bp;
            logic [WIDTH-1:0] r_res;
            logic             r_cy;
            logic             r_z;
            logic             r_sub;
            logic             r_sign;
            logic [TAG_W-1:0] r_tag;
`ifdef ADDSUB_SAT_EN
            logic             r_sat;
`endif

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vld  <= 1'b0;
                    r_a    <= '0;
                    r_bp   <= '0;
                    r_res  <= '0;
                    r_cy   <= 1'b0;
                    r_z    <= 1'b0;
                    r_sub  <= 1'b0;
                    r_sign <= 1'b0;
                    r_tag  <= '0;
`ifdef ADDSUB_SAT_EN
                    r_sat  <= 1'b0;
`endif
                end else if (w_en) begin
                    r_vld  <= w_vld_in[k];
                    r_a    <= w_a_in[k];
                    r_bp   <= w_bp_in[k];
                    r_res  <= w_res_nx;
                    r_cy   <= w_cout;
                    r_z    <= w_z_nx;
                    r_sub  <= w_sub_in[k];
                    r_sign <= w_sign_in[k];
                    r_tag  <= w_tag_in[k];
`ifdef ADDSUB_SAT_EN
                    r_sat  <= w_sat_in[k];
`endif
                end
            end

            assign w_vld_in[k+1]  = r_vld;
            assign w_a_in[k+1]    = r_a;
            assign w_bp_in[k+1]   = r_bp;
            assign w_res_in[k+1]  = r_res;
            assign w_cin_in[k+1]  = r_cy;
            assign w_z_in[k+1]    = r_z;
            assign w_sub_in[k+1]  = r_sub;
            assign w_sign_in[k+1] = r_sign;
            assign w_tag_in[k+1]  = r_tag;
`ifdef ADDSUB_SAT_EN
            assign w_sat_in[k+1]  = r_sat;
`endif
        end else begin : g_final
            logic             w_a_msb;
            logic             w_v;
            logic             w_z;
            logic             w_n;
            logic [WIDTH-1:0] w_s;

            assign w_a_msb = w_a_in[k][MSB];
            // Unsigned: v is the carry for add and the borrow (~carry) for sub.
            assign w_v = (w_sign_in[k] == SIGN_S)
                       ? ((w_a_msb == w_bp_in[k][MSB]) && (w_res_nx[MSB] != w_a_msb))
                       : ((w_sub_in[k] == OP_ADD) ? w_cout : ~w_cout);

`ifdef ADDSUB_SAT_EN
            logic             w_clamp;
            logic [WIDTH-1:0] w_clamp_val;

            always_comb begin
                w_clamp_val = '0;
                case (clamp_kind(w_sign_in[k], w_sub_in[k], w_a_msb))
                    CLAMP_ONES:   w_clamp_val = '1;
                    CLAMP_MAXPOS: w_clamp_val = {1'b0, {(WIDTH-1){1'b1}}};
                    CLAMP_MINNEG: w_clamp_val = {1'b1, {(WIDTH-1){1'b0}}};
                    default:      w_clamp_val = '0;
                endcase
            end

            assign w_clamp = w_sat_in[k] & w_v;
            assign w_s     = w_clamp ? w_clamp_val : w_res_nx;
            assign w_z     = w_clamp ? (w_clamp_val == '0) : w_z_nx;
`else
            assign w_s     = w_res_nx;
            assign w_z     = w_z_nx;
`endif
            assign w_n = (w_sign_in[k] == SIGN_U) ? 1'b0 : w_s[MSB];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_out_valid <= 1'b0;
                    r_s         <= '0;
                    r_flags     <= '0;
                    r_out_tag   <= '0;
                end else if (w_en) begin
                    r_out_valid <= w_vld_in[k];
                    r_s         <= w_s;
                    r_flags     <= '{z: w_z, v: w_v, n: w_n, c: w_cout};
                    r_out_tag   <= w_tag_in[k];
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign z         = r_flags.z;
    assign v         = r_flags.v;
    assign n         = r_flags.n;
    assign c         = r_flags.c;
    assign out_tag   = r_out_tag;

endmodule

`default_nettype wire
